// File: rtl/mem_uart_streamer_pkg.sv
// Shared types and constants for the memory-to-UART readback engine.
package mem_uart_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SEND,
    ST_FINISH
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;

endpackage

// File: rtl/word_serializer.sv
// Holds one 32-bit word and hands it to the UART stream one byte at a time
// over a stb/ack handshake; pulses last_byte_acked_o when the final byte goes.
module word_serializer
  import mem_uart_streamer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        tx_ack_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_stb_o,
  output logic        last_byte_acked_o
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [31:0]           word_q, word_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic                  stb_q, stb_d;
  logic [7:0]            data_q, data_d;
  logic                  accept;

  // Send order index -> byte lane; reversing a 2-bit index is a bitwise invert.
  function automatic logic [7:0] pick(input logic [31:0] w, input logic [BYTE_IDX_W-1:0] idx);
    logic [BYTE_IDX_W-1:0] lane;
    lane = MSB_FIRST ? ~idx : idx;
    return w[8*lane +: 8];
  endfunction

  assign accept            = stb_q & tx_ack_i;
  assign last_byte_acked_o = accept && (idx_q == LAST_IDX);

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latch).
    word_d = word_q;
    idx_d  = idx_q;
    stb_d  = stb_q;
    data_d = data_q;
    if (load_i) begin
      word_d = word_i;
      idx_d  = '0;
      stb_d  = 1'b1;
      data_d = pick(word_i, '0);
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        stb_d = 1'b0;
      end else begin
        idx_d  = idx_q + 1'b1;
        data_d = pick(word_q, idx_q + 1'b1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
      stb_q  <= 1'b0;
      data_q <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      stb_q  <= stb_d;
      data_q <= data_d;
    end
  end

  assign tx_data_o = data_q;
  assign tx_stb_o  = stb_q;

endmodule

// File: rtl/mem_uart_streamer.sv
// Reads a block of words from memory port b and streams each one, as four
// bytes, into the UART transmit handshake. busy lets the top level own port b.
module mem_uart_streamer
  import mem_uart_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_dr,
  output logic [7:0]            tx_data,
  output logic                  tx_stb,
  input  logic                  tx_ack,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q;
  logic                  start_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  mem_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  launch;
  logic                  last_byte_acked;

  assign launch = start & ~start_q;

  word_serializer #(
    .MSB_FIRST(MSB_FIRST)
  ) u_ser (
    .clk              (clk),
    .rst              (rst),
    .load_i           (state_q == ST_LATCH),
    .word_i           (mem_dr),
    .tx_ack_i         (tx_ack),
    .tx_data_o        (tx_data),
    .tx_stb_o         (tx_stb),
    .last_byte_acked_o(last_byte_acked)
  );

  // mem_en/mem_addr are loaded on entry to READ so they are valid for exactly that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      start_q  <= start;
      mem_en_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (launch) begin
            addr_q      <= base_addr;
            remaining_q <= word_count;
            busy_q      <= 1'b1;
            if (word_count == '0) begin
              state_q <= ST_FINISH;
            end else begin
              state_q    <= ST_READ;
              mem_en_q   <= 1'b1;
              mem_addr_q <= base_addr;
            end
          end
        end
        ST_READ: state_q <= ST_LATCH;
        ST_LATCH: begin
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (last_byte_acked) begin
            if (remaining_q != '0) begin
              state_q    <= ST_READ;
              mem_en_q   <= 1'b1;
              mem_addr_q <= addr_q;
            end else begin
              state_q <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_we   = 1'b0;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
